usb_symbol_parser: RTL and testbench
====================================

USB_SYMBOL_PARSER -- requirements
Module: usb_symbol_parser

Interface
REQ-001 Parameter: TIMEOUT, default 1000000, max clk cycles allowed between consecutive bytes of one frame.
REQ-002 Parameter: SYNC, default 8'hA5, frame start byte.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_  input  1  reset, asynchronous, active-low.
REQ-005 byte_in  input  8  received USB byte from the FT245R read stage.
REQ-006 byte_valid  input  1  one-cycle strobe; byte_in is valid in that cycle.
REQ-007 i_out  output  16  last accepted I value.
REQ-008 q_out  output  16  last accepted Q value.
REQ-009 sym_valid  output  1  one-cycle pulse when i_out and q_out update.
REQ-010 err_cnt  output  8  saturating count of checksum and timeout errors.
REQ-011 busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-012 Frame format, 6 bytes in order: SYNC, I[15:8], I[7:0], Q[15:8], Q[7:0], CHK.
REQ-013 CHK is the XOR of the four payload bytes.
REQ-014 FSM states: IDLE, I_HI, I_LO, Q_HI, Q_LO, CHK.
REQ-015 Each state advances only on a cycle with byte_valid=1.
REQ-016 IDLE: byte_valid with byte_in==SYNC goes to I_HI; any other byte is silently dropped (no error count).
REQ-017 I_HI -> I_LO -> Q_HI -> Q_LO -> CHK: each byte is latched into an internal shadow register and XORed into a running checksum cleared on SYNC.
REQ-018 SYNC values inside payload or CHK positions are treated as data (no resync).
REQ-019 CHK state, byte matches running checksum: next cycle i_out/q_out load the shadow values, sym_valid=1 for exactly one cycle, FSM returns to IDLE.
REQ-020 CHK state, byte mismatches: i_out/q_out unchanged, sym_valid stays 0, err_cnt increments, FSM returns to IDLE.
REQ-021 Latency: sym_valid rises on the first rising edge after the clock edge that samples the valid CHK byte.
REQ-022 Gap counter: cleared on every accepted byte and held at 0 in IDLE; increments each cycle in non-IDLE states without byte_valid.
REQ-023 Gap counter reaches TIMEOUT: FSM goes to IDLE, err_cnt increments, partial frame discarded, outputs unchanged.
REQ-024 byte_valid in the same cycle the gap counter reaches TIMEOUT: the byte is accepted; no timeout occurs.
REQ-025 err_cnt saturates at 8'hFF; no wrap.
REQ-026 Checksum error and timeout cannot occur in the same cycle; each event adds exactly 1.
REQ-027 i_out and q_out hold their values between sym_valid pulses.
REQ-028 Gap counter width is sufficient for TIMEOUT (at least 32 bits) and does not wrap before reaching TIMEOUT.

Reset
REQ-029 rst_ low immediately forces: FSM=IDLE; i_out=0; q_out=0; sym_valid=0; err_cnt=0; busy=0; gap counter, shadow registers and checksum cleared.
REQ-030 Reset mid-frame discards the partial frame; the first frame after release parses normally.

Verification
REQ-031 Good frame: bytes A5,12,34,56,78,08 -> i_out=16'h1234, q_out=16'h5678, one sym_valid pulse, err_cnt=0.
REQ-032 Bad checksum: A5,12,34,56,78,09 -> no sym_valid, outputs unchanged, err_cnt=1.
REQ-033 Garbage then frame: 00,FF,A5,00,A5,00,A5,00 -> data bytes after SYNC parsed, i_out=16'h00A5, q_out=16'h00A5, sym_valid pulse.
REQ-034 Timeout, with TIMEOUT=16: A5,12, then idle 16 cycles -> FSM back to IDLE, err_cnt=1; a following good frame is accepted.
REQ-035 Saturation: 260 bad frames -> err_cnt=8'hFF.
REQ-036 Reset: assert rst_ after byte 3 of a frame -> all outputs 0 asynchronously; a full good frame after release gives a correct sym_valid.

Source files
------------

// File: rtl/usb_symbol_parser.sv
// usb_symbol_parser
// Parses 6-byte I/Q frames (SYNC, I_hi, I_lo, Q_hi, Q_lo, CHK) arriving as
// byte strobes from the FT245R read stage. A frame whose XOR checksum matches
// updates i_out/q_out with a single-cycle sym_valid pulse. Checksum failures
// and inter-byte timeouts are counted in a saturating error counter.
module usb_symbol_parser #(
   parameter int unsigned TIMEOUT = 1000000,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic [15:0] i_out,
   output logic [15:0] q_out,
   output logic        sym_valid,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_I_HI = 3'd1;
   localparam logic [2:0] ST_I_LO = 3'd2;
   localparam logic [2:0] ST_Q_HI = 3'd3;
   localparam logic [2:0] ST_Q_LO = 3'd4;
   localparam logic [2:0] ST_CHK  = 3'd5;

   // Gap count at which an idle cycle expires the frame; the counter is
   // cleared on expiry so it can never wrap.
   localparam logic [31:0] GAP_LAST = 32'(TIMEOUT - 1);

   logic [2:0]  state;
   logic [31:0] gap_cnt;
   logic [15:0] i_sh;
   logic [15:0] q_sh;
   logic [7:0]  chk_acc;

   logic        vld_p0;
   logic [15:0] i_p0;
   logic [15:0] q_p0;

   logic        timeout_hit;
   logic        chk_good;
   logic        chk_bad;

   // Saturating increment for the error counter.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A byte arriving in the expiry cycle wins over the timeout.
   assign timeout_hit = (state != ST_IDLE) && !byte_valid && (gap_cnt == GAP_LAST);
   assign chk_good    = (state == ST_CHK) && byte_valid && (byte_in == chk_acc);
   assign chk_bad     = (state == ST_CHK) && byte_valid && (byte_in != chk_acc);
   assign busy        = (state != ST_IDLE);

   // Frame state machine: advances only on byte strobes, falls back to IDLE on timeout.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (byte_valid && byte_in == SYNC) state <= ST_I_HI;
            ST_I_HI: if (byte_valid) state <= ST_I_LO;
                     else if (timeout_hit) state <= ST_IDLE;
            ST_I_LO: if (byte_valid) state <= ST_Q_HI;
                     else if (timeout_hit) state <= ST_IDLE;
            ST_Q_HI: if (byte_valid) state <= ST_Q_LO;
                     else if (timeout_hit) state <= ST_IDLE;
            ST_Q_LO: if (byte_valid) state <= ST_CHK;
                     else if (timeout_hit) state <= ST_IDLE;
            ST_CHK:  if (byte_valid || timeout_hit) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Inter-byte gap counter: held at zero in IDLE, cleared by every accepted byte.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         gap_cnt <= '0;
      end else if (state == ST_IDLE || byte_valid || timeout_hit) begin
         gap_cnt <= '0;
      end else begin
         gap_cnt <= gap_cnt + 32'd1;
      end
   end

   // Shadow I/Q and running checksum; SYNC inside a frame is plain data.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         i_sh    <= '0;
         q_sh    <= '0;
         chk_acc <= '0;
      end else if (byte_valid) begin
         case (state)
            ST_IDLE: if (byte_in == SYNC) chk_acc <= '0;
            ST_I_HI: begin
               i_sh[15:8] <= byte_in;
               chk_acc    <= chk_acc ^ byte_in;
            end
            ST_I_LO: begin
               i_sh[7:0] <= byte_in;
               chk_acc   <= chk_acc ^ byte_in;
            end
            ST_Q_HI: begin
               q_sh[15:8] <= byte_in;
               chk_acc    <= chk_acc ^ byte_in;
            end
            ST_Q_LO: begin
               q_sh[7:0] <= byte_in;
               chk_acc   <= chk_acc ^ byte_in;
            end
            default: ;
         endcase
      end
   end

   // ---- stage p0: checksum verdict captured with a snapshot of the shadow pair
   // Valid flag for the accepted symbol.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= chk_good;
      end
   end

   // Symbol snapshot; only consumed when vld_p0 is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (chk_good) begin
         i_p0 <= i_sh;
         q_p0 <= q_sh;
      end
   end

   // ---- stage p1: registered outputs, held between pulses
   // Output update and single-cycle sym_valid pulse.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         i_out     <= '0;
         q_out     <= '0;
         sym_valid <= 1'b0;
      end else begin
         sym_valid <= vld_p0;
         if (vld_p0) begin
            i_out <= i_p0;
            q_out <= q_p0;
         end
      end
   end

   // Error counter: checksum failures and timeouts are mutually exclusive per cycle.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         err_cnt <= '0;
      end else if (chk_bad || timeout_hit) begin
         err_cnt <= sat_inc(err_cnt);
      end
   end

endmodule

// File: tb/tb_usb_symbol_parser.sv
// Scoreboard bench for usb_symbol_parser: directed frames push expected I/Q
// pairs into a queue; a monitor pops one entry per sym_valid pulse.
module tb_usb_symbol_parser;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic [15:0] i_out;
   logic [15:0] q_out;
   logic        sym_valid;
   logic [7:0]  err_cnt;
   logic        busy;

   usb_symbol_parser #(.TIMEOUT(TO), .SYNC(8'hA5)) dut (
      .clk        (clk),
      .rst_       (rst_),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .i_out      (i_out),
      .q_out      (q_out),
      .sym_valid  (sym_valid),
      .err_cnt    (err_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   logic [31:0] exp_q[$];
   int          n_assert = 0;
   int          n_fail = 0;
   logic [15:0] last_i = 16'h0000;
   logic [15:0] last_q = 16'h0000;
   logic [7:0]  exp_err = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_good(input logic [15:0] i, input logic [15:0] q);
      exp_q.push_back({i, q});
      last_i = i;
      last_q = q;
   endtask

   task automatic expect_bad();
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
   endtask

   // Frame with computed checksum; bad frames flip the low checksum bit.
   task automatic send_frame(input logic [15:0] i, input logic [15:0] q,
                             input bit good, input int gap);
      logic [7:0] chk;
      chk = i[15:8] ^ i[7:0] ^ q[15:8] ^ q[7:0];
      if (good) expect_good(i, q);
      else begin
         chk = chk ^ 8'h01;
         expect_bad();
      end
      send_byte(8'hA5); idle(gap);
      send_byte(i[15:8]); idle(gap);
      send_byte(i[7:0]); idle(gap);
      send_byte(q[15:8]); idle(gap);
      send_byte(q[7:0]); idle(gap);
      send_byte(chk);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_i"}, 32'(i_out), 32'(last_i));
      check({tag, "_q"}, 32'(q_out), 32'(last_q));
      check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Monitor: every sym_valid pulse must match the oldest expected symbol.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_ && sym_valid) begin
         if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL sym_unexpected: got i=%0h q=%0h, expected no pulse", i_out, q_out);
         end else begin
            e = exp_q.pop_front();
            check("sym_iq", {i_out, q_out}, e);
         end
      end
   end

   initial begin
      // Reset state
      idle(3);
      check("rst_i", 32'(i_out), 32'd0);
      check("rst_q", 32'(q_out), 32'd0);
      check("rst_sym", 32'(sym_valid), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_ = 1'b1;
      idle(2);

      // Good frame
      expect_good(16'h1234, 16'h5678);
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'h56); send_byte(8'h78); send_byte(8'h08);
      idle(4);
      check_outputs("good");

      // Bad checksum
      expect_bad();
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'h56); send_byte(8'h78); send_byte(8'h09);
      idle(4);
      check_outputs("badchk");

      // Garbage, then SYNC values used as payload
      expect_good(16'h00A5, 16'h00A5);
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'hA5); send_byte(8'h00);
      idle(4);
      check_outputs("garbage");

      // Gapped good frame
      send_frame(16'hBEEF, 16'hCAFE, 1'b1, 5);
      idle(4);
      check_outputs("gapped");

      // Byte arriving exactly in the expiry cycle is accepted
      send_frame(16'hA55A, 16'h0FF0, 1'b1, TO - 1);
      idle(4);
      check_outputs("edge");

      // Timeout mid-frame
      send_byte(8'hA5); send_byte(8'h12);
      idle(TO - 2);
      check("to_busy_pending", 32'(busy), 32'd1);
      idle(4);
      expect_bad();
      check_outputs("timeout");
      send_frame(16'h1111, 16'h2222, 1'b1, 0);
      idle(4);
      check_outputs("after_to");

      // Saturation
      for (int k = 0; k < 260; k++) send_frame(16'(k), 16'(~k), 1'b0, 0);
      idle(4);
      check_outputs("sat");
      check("sat_ff", 32'(err_cnt), 32'hFF);
      send_frame(16'h7FFF, 16'h8000, 1'b1, 0);
      idle(4);
      check_outputs("after_sat");

      // Asynchronous reset mid-frame
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      #2;
      rst_ = 1'b0;
      #1;
      last_i  = 16'h0000;
      last_q  = 16'h0000;
      exp_err = 8'h00;
      check("arst_sym", 32'(sym_valid), 32'd0);
      check_outputs("arst");
      idle(2);
      rst_ = 1'b1;
      idle(1);
      expect_good(16'h1234, 16'h5678);
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'h56); send_byte(8'h78); send_byte(8'h08);
      idle(4);
      check_outputs("post_rst");

      idle(5);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
